// File: rtl/rsa_job_arbiter.sv
// Shares one modular-exponentiation unit between two requesters: round-robin grant,
// operand latch, one-cycle local reset of the unit, run to eoc or timeout, result return.
module rsa_job_arbiter #(
  parameter int WIDTH = 8,
  parameter int TO_W  = 10
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req0,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] e0,
  input  logic [WIDTH-1:0] m0,
  input  logic [WIDTH-1:0] k0,
  input  logic             req1,
  input  logic [WIDTH-1:0] p1,
  input  logic [WIDTH-1:0] e1,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] k1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             rsa_rstb,
  output logic             rsa_en,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_e,
  output logic [WIDTH-1:0] rsa_m,
  output logic [WIDTH-1:0] rsa_k,
  input  logic [WIDTH-1:0] rsa_c,
  input  logic             rsa_eoc
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // cnt_r holds RUN cycles already elapsed, so the RUN cycle seeing CNT_LAST is number 2**TO_W-1.
  localparam logic [TO_W-1:0] CNT_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_r;
  logic             win_r;
  logic [TO_W-1:0]  cnt_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] op_p_r, op_e_r, op_m_r, op_k_r;
  logic             gnt0_r, gnt1_r, done0_r, done1_r, err0_r, err1_r, busy_r, rsa_en_r;

  logic             any_req_s;
  logic             pick_s;
  logic             grant_s;
  logic             last_run_s;
  logic             gnt0_nxt_s, gnt1_nxt_s, done0_nxt_s, done1_nxt_s;
  logic             err0_nxt_s, err1_nxt_s, busy_nxt_s, rsa_en_nxt_s;

  // On a tie the requester that did not win last time gets the grant.
  assign any_req_s  = req0 | req1;
  assign pick_s     = (req0 & req1) ? ~last_r : req1;
  assign grant_s    = (state_r == ST_IDLE) & any_req_s;
  assign last_run_s = (cnt_r == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; eoc wins over timeout in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (rsa_eoc) begin
          state_nxt_s = ST_DONE;
        end else if (last_run_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered control outputs
  always_comb begin
    gnt0_nxt_s   = grant_s & ~pick_s;
    gnt1_nxt_s   = grant_s &  pick_s;
    done0_nxt_s  = (state_nxt_s == ST_DONE) & ~win_r;
    done1_nxt_s  = (state_nxt_s == ST_DONE) &  win_r;
    err0_nxt_s   = (state_nxt_s == ST_ERR)  & ~win_r;
    err1_nxt_s   = (state_nxt_s == ST_ERR)  &  win_r;
    busy_nxt_s   = (state_nxt_s != ST_IDLE);
    rsa_en_nxt_s = (state_nxt_s == ST_RUN);
  end

  // Control output registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      busy_r   <= 1'b0;
      rsa_en_r <= 1'b0;
    end else begin
      gnt0_r   <= gnt0_nxt_s;
      gnt1_r   <= gnt1_nxt_s;
      done0_r  <= done0_nxt_s;
      done1_r  <= done1_nxt_s;
      err0_r   <= err0_nxt_s;
      err1_r   <= err1_nxt_s;
      busy_r   <= busy_nxt_s;
      rsa_en_r <= rsa_en_nxt_s;
    end
  end

  // Datapath: operand latch on grant, fairness pointer, timeout counter, result
  always_ff @(posedge clk) begin
    if (!rstb) begin
      last_r <= 1'b1;
      win_r  <= 1'b0;
      cnt_r  <= {TO_W{1'b0}};
      res_r  <= {WIDTH{1'b0}};
      op_p_r <= {WIDTH{1'b0}};
      op_e_r <= {WIDTH{1'b0}};
      op_m_r <= {WIDTH{1'b0}};
      op_k_r <= {WIDTH{1'b0}};
    end else begin
      if (grant_s) begin
        last_r <= pick_s;
        win_r  <= pick_s;
        op_p_r <= pick_s ? p1 : p0;
        op_e_r <= pick_s ? e1 : e0;
        op_m_r <= pick_s ? m1 : m0;
        op_k_r <= pick_s ? k1 : k0;
      end
      if (state_r == ST_CLEAR) begin
        cnt_r <= {TO_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if ((state_r == ST_RUN) && rsa_eoc) begin
        res_r <= rsa_c;
      end
    end
  end

  assign gnt0     = gnt0_r;
  assign gnt1     = gnt1_r;
  assign done0    = done0_r;
  assign done1    = done1_r;
  assign err0     = err0_r;
  assign err1     = err1_r;
  assign busy     = busy_r;
  assign rsa_en   = rsa_en_r;
  assign res      = res_r;
  assign rsa_p    = op_p_r;
  assign rsa_e    = op_e_r;
  assign rsa_m    = op_m_r;
  assign rsa_k    = op_k_r;
  assign rsa_rstb = rstb & (state_r != ST_CLEAR);

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed bench for rsa_job_arbiter: instance A (TO_W=10) and instance B (TO_W=4),
// each driving a behavioural rsa_unit stub that raises eoc after a set number of RUN cycles.
module tb_rsa_job_arbiter;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] p0 = 8'd0, e0 = 8'd0, m0 = 8'd0, k0 = 8'd0;
  logic [7:0] p1 = 8'd0, e1 = 8'd0, m1 = 8'd0, k1 = 8'd0;

  logic gnt0_a, gnt1_a, done0_a, done1_a, err0_a, err1_a, busy_a, rsa_rstb_a, rsa_en_a, rsa_eoc_a;
  logic gnt0_b, gnt1_b, done0_b, done1_b, err0_b, err1_b, busy_b, rsa_rstb_b, rsa_en_b, rsa_eoc_b;
  logic [7:0] res_a, rsa_p_a, rsa_e_a, rsa_m_a, rsa_k_a, rsa_c_a;
  logic [7:0] res_b, rsa_p_b, rsa_e_b, rsa_m_b, rsa_k_b, rsa_c_b;

  int n_a = 20, n_b = 3;
  int scnt_a, scnt_b;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  rsa_job_arbiter #(.WIDTH(8), .TO_W(10)) dut_a (
    .clk(clk), .rstb(rstb),
    .req0(req0), .p0(p0), .e0(e0), .m0(m0), .k0(k0),
    .req1(req1), .p1(p1), .e1(e1), .m1(m1), .k1(k1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
    .err0(err0_a), .err1(err1_a), .res(res_a), .busy(busy_a),
    .rsa_rstb(rsa_rstb_a), .rsa_en(rsa_en_a),
    .rsa_p(rsa_p_a), .rsa_e(rsa_e_a), .rsa_m(rsa_m_a), .rsa_k(rsa_k_a),
    .rsa_c(rsa_c_a), .rsa_eoc(rsa_eoc_a)
  );

  rsa_job_arbiter #(.WIDTH(8), .TO_W(4)) dut_b (
    .clk(clk), .rstb(rstb),
    .req0(req0), .p0(p0), .e0(e0), .m0(m0), .k0(k0),
    .req1(req1), .p1(p1), .e1(e1), .m1(m1), .k1(k1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
    .err0(err0_b), .err1(err1_b), .res(res_b), .busy(busy_b),
    .rsa_rstb(rsa_rstb_b), .rsa_en(rsa_en_b),
    .rsa_p(rsa_p_b), .rsa_e(rsa_e_b), .rsa_m(rsa_m_b), .rsa_k(rsa_k_b),
    .rsa_c(rsa_c_b), .rsa_eoc(rsa_eoc_b)
  );

  function automatic logic [7:0] modexp(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
    int r, pi, ei, mi;
    pi = int'(p); ei = int'(e); mi = int'(m);
    if (mi == 0) return 8'd0;
    r = 1 % mi;
    for (int i = 0; i < ei; i++) r = (r * pi) % mi;
    return r[7:0];
  endfunction

  // Stub units: counter cleared by the local reset, eoc once n RUN cycles have elapsed
  always_ff @(posedge clk) begin
    if (!rsa_rstb_a) scnt_a <= 0;
    else if (rsa_en_a) scnt_a <= scnt_a + 1;
  end
  always_ff @(posedge clk) begin
    if (!rsa_rstb_b) scnt_b <= 0;
    else if (rsa_en_b) scnt_b <= scnt_b + 1;
  end
  assign rsa_eoc_a = rsa_en_a && (scnt_a >= n_a);
  assign rsa_eoc_b = rsa_en_b && (scnt_b >= n_b);
  assign rsa_c_a   = modexp(rsa_p_a, rsa_e_a, rsa_m_a);
  assign rsa_c_b   = modexp(rsa_p_b, rsa_e_b, rsa_m_b);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_end(input bit use_b);
    return use_b ? bit'(done0_b | done1_b | err0_b | err1_b) : bit'(done0_a | done1_a | err0_a | err1_a);
  endfunction

  task automatic wait_end(input bit use_b, input int budget);
    int cyc = 0;
    while (cyc < budget && !any_end(use_b)) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_gnt_a(output int cyc, output logic busy_before);
    cyc = 0;
    busy_before = 1'b0;
    while (cyc < 40 && !(gnt0_a | gnt1_a)) begin
      busy_before = busy_a;
      step();
      cyc++;
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rstb = 1'b0;
    step(); step();
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    step(); step();
    total_cnt++; if ({gnt0_a, gnt1_a, done0_a, done1_a, err0_a, err1_a, busy_a, rsa_en_a} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000", {gnt0_a, gnt1_a, done0_a, done1_a, err0_a, err1_a, busy_a, rsa_en_a}); else pass_cnt++;
    total_cnt++; if ({res_a, rsa_p_a, rsa_e_a, rsa_m_a, rsa_k_a} !== 40'd0)
      $display("FAIL reset_data: got %h want 0", {res_a, rsa_p_a, rsa_e_a, rsa_m_a, rsa_k_a}); else pass_cnt++;
    total_cnt++; if (rsa_rstb_a !== 1'b0) $display("FAIL reset_rsa_rstb_low: got %b want 0", rsa_rstb_a); else pass_cnt++;
    rstb = 1'b1;
    #1;
    total_cnt++; if (rsa_rstb_a !== 1'b1) $display("FAIL reset_rsa_rstb_high: got %b want 1", rsa_rstb_a); else pass_cnt++;
  endtask

  task automatic test_single();
    p0 = 8'd5; e0 = 8'd3; m0 = 8'd33; k0 = 8'd9; n_a = 20;
    req0 = 1'b1;
    step();
    total_cnt++; if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) $display("FAIL single_gnt: got %b%b want 10", gnt0_a, gnt1_a); else pass_cnt++;
    total_cnt++; if (rsa_rstb_a !== 1'b0 || rsa_en_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL single_clear: got rstb=%b en=%b busy=%b want 0 0 1", rsa_rstb_a, rsa_en_a, busy_a); else pass_cnt++;
    total_cnt++; if ({rsa_p_a, rsa_e_a, rsa_m_a, rsa_k_a} !== {8'd5, 8'd3, 8'd33, 8'd9})
      $display("FAIL single_ops: got %h want 05032109", {rsa_p_a, rsa_e_a, rsa_m_a, rsa_k_a}); else pass_cnt++;
    req0 = 1'b0;
    step();
    total_cnt++; if (rsa_rstb_a !== 1'b1 || rsa_en_a !== 1'b1 || gnt0_a !== 1'b0)
      $display("FAIL single_run: got rstb=%b en=%b gnt0=%b want 1 1 0", rsa_rstb_a, rsa_en_a, gnt0_a); else pass_cnt++;
    wait_end(1'b0, 100);
    total_cnt++; if (done0_a !== 1'b1 || err0_a !== 1'b0) $display("FAIL single_done: got done0=%b err0=%b want 1 0", done0_a, err0_a); else pass_cnt++;
    total_cnt++; if (res_a !== 8'h1A) $display("FAIL single_res: got %h want 1a", res_a); else pass_cnt++;
    step();
    total_cnt++; if (busy_a !== 1'b0 || done0_a !== 1'b0) $display("FAIL single_idle: got busy=%b done0=%b want 0 0", busy_a, done0_a); else pass_cnt++;
  endtask

  task automatic test_tie();
    int cyc;
    logic bb;
    do_reset();
    n_a = 20;
    p0 = 8'd5; e0 = 8'd3; m0 = 8'd33;
    p1 = 8'd7; e1 = 8'd2; m1 = 8'd11;
    req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_gnt_a(cyc, bb);
      total_cnt++; if ({gnt0_a, gnt1_a} !== ((j % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL tie_gnt_%0d: got %b%b", j, gnt0_a, gnt1_a); else pass_cnt++;
      total_cnt++; if (cyc != ((j == 0) ? 1 : 2)) $display("FAIL tie_gap_%0d: got %0d want %0d", j, cyc, (j == 0) ? 1 : 2); else pass_cnt++;
      total_cnt++; if (bb !== 1'b0) $display("FAIL tie_busy_overlap_%0d: got busy=%b before grant want 0", j, bb); else pass_cnt++;
      if (j == 3) begin req0 = 1'b0; req1 = 1'b0; end
      wait_end(1'b0, 100);
      total_cnt++; if ({done0_a, done1_a} !== ((j % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL tie_done_%0d: got %b%b", j, done0_a, done1_a); else pass_cnt++;
      total_cnt++; if (res_a !== ((j % 2 == 0) ? 8'd26 : 8'd5))
        $display("FAIL tie_res_%0d: got %0d want %0d", j, res_a, (j % 2 == 0) ? 26 : 5); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int runs = 0;
    int cyc = 0;
    do_reset();
    n_b = 3;
    p0 = 8'd5; e0 = 8'd3; m0 = 8'd33;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    wait_end(1'b1, 100);
    total_cnt++; if (done0_b !== 1'b1 || res_b !== 8'd26) $display("FAIL to_prejob: got done0=%b res=%0d want 1 26", done0_b, res_b); else pass_cnt++;
    step();
    n_b = 1000;
    p0 = 8'd7; e0 = 8'd2; m0 = 8'd11;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    while (cyc < 100 && !any_end(1'b1)) begin
      step();
      cyc++;
      if (rsa_en_b) runs++;
    end
    total_cnt++; if (err0_b !== 1'b1 || done0_b !== 1'b0) $display("FAIL to_err: got err0=%b done0=%b want 1 0", err0_b, done0_b); else pass_cnt++;
    total_cnt++; if (runs != 15) $display("FAIL to_runs: got %0d want 15", runs); else pass_cnt++;
    total_cnt++; if (res_b !== 8'd26 || rsa_en_b !== 1'b0) $display("FAIL to_res: got res=%0d en=%b want 26 0", res_b, rsa_en_b); else pass_cnt++;
  endtask

  task automatic test_eoc_last();
    step();
    n_b = 14;
    p0 = 8'd7; e0 = 8'd2; m0 = 8'd11;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    wait_end(1'b1, 100);
    total_cnt++; if (done0_b !== 1'b1 || err0_b !== 1'b0) $display("FAIL eoc_last: got done0=%b err0=%b want 1 0", done0_b, err0_b); else pass_cnt++;
    total_cnt++; if (res_b !== 8'd5) $display("FAIL eoc_last_res: got %0d want 5", res_b); else pass_cnt++;
    step();
    n_b = 15;
    p0 = 8'd3; e0 = 8'd4; m0 = 8'd7;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    wait_end(1'b1, 100);
    total_cnt++; if (err0_b !== 1'b1 || done0_b !== 1'b0 || res_b !== 8'd5)
      $display("FAIL eoc_late: got err0=%b done0=%b res=%0d want 1 0 5", err0_b, done0_b, res_b); else pass_cnt++;
  endtask

  task automatic test_withdraw();
    do_reset();
    n_a = 20;
    p1 = 8'd3; e1 = 8'd4; m1 = 8'd7;
    req1 = 1'b1;
    step();
    total_cnt++; if (gnt1_a !== 1'b1 || gnt0_a !== 1'b0) $display("FAIL wd_gnt1: got %b%b want 01", gnt0_a, gnt1_a); else pass_cnt++;
    step();
    req1 = 1'b0;
    wait_end(1'b0, 100);
    total_cnt++; if (done1_a !== 1'b1 || done0_a !== 1'b0 || res_a !== 8'd4)
      $display("FAIL wd_done1: got done1=%b done0=%b res=%0d want 1 0 4", done1_a, done0_a, res_a); else pass_cnt++;
    step(); step();
    total_cnt++; if (busy_a !== 1'b0 || gnt1_a !== 1'b0) $display("FAIL wd_no_regrant: got busy=%b gnt1=%b want 0 0", busy_a, gnt1_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    do_reset();
    n_a = 20;
    p0 = 8'd5; e0 = 8'd3; m0 = 8'd33;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    repeat (5) step();
    total_cnt++; if (rsa_en_a !== 1'b1) $display("FAIL mid_in_run: got en=%b want 1", rsa_en_a); else pass_cnt++;
    rstb = 1'b0;
    step();
    total_cnt++; if ({busy_a, rsa_en_a, rsa_rstb_a, done0_a, err0_a} !== 5'b00000)
      $display("FAIL mid_ctrl: got %b want 00000", {busy_a, rsa_en_a, rsa_rstb_a, done0_a, err0_a}); else pass_cnt++;
    total_cnt++; if ({res_a, rsa_p_a, rsa_e_a, rsa_m_a} !== 32'd0)
      $display("FAIL mid_data: got %h want 0", {res_a, rsa_p_a, rsa_e_a, rsa_m_a}); else pass_cnt++;
    rstb = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (any_end(1'b0) || busy_a) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL mid_silent: got activity=%b want 0", seen); else pass_cnt++;
    p0 = 8'd7; e0 = 8'd2; m0 = 8'd11;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    total_cnt++; if (gnt0_a !== 1'b1) $display("FAIL mid_regrant: got %b want 1", gnt0_a); else pass_cnt++;
    wait_end(1'b0, 100);
    total_cnt++; if (done0_a !== 1'b1 || res_a !== 8'd5) $display("FAIL mid_redone: got done0=%b res=%0d want 1 5", done0_a, res_a); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_eoc_last();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
